// File: rtl/systolic_pingpong_buffer.sv
// -----------------------------------------------------------------------------
// systolic_pingpong_buffer
// Double-banked result buffer between the systolic array (writer) and the
// downstream consumer (reader). One bank is filled while the other drains;
// ownership moves through a done/ready handshake. The write side supports
// per-lane masks and an in-place accumulate mode (two-stage read-modify-write
// with forwarding so back-to-back accumulates to one row sum correctly).
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   wr_en/wr_addr/wr_mask   row write into the current write bank
//   wr_acc/wr_data          1 = add to stored lanes, 0 = overwrite
//   wr_done/wr_ready        hand the write bank to the reader / bank is free
//   rd_en/rd_addr           row read from the current read bank
//   rd_done/rd_ready        release the read bank / bank holds a full tile
//   rd_data/rd_valid        registered read data, valid one cycle after rd_en
//   err[2:0]                sticky: [0] write rejected, [1] read rejected,
//                           [2] address out of range
// -----------------------------------------------------------------------------
module systolic_pingpong_buffer #(
    parameter int DATAWIDTH  = 32,
    parameter int N_SIZE     = 32,
    parameter int DEPTH      = 543,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        wr_en,
    input  logic [ADDR_WIDTH-1:0]       wr_addr,
    input  logic [N_SIZE-1:0]           wr_mask,
    input  logic                        wr_acc,
    input  logic [DATAWIDTH*N_SIZE-1:0] wr_data,
    input  logic                        wr_done,
    output logic                        wr_ready,
    input  logic                        rd_en,
    input  logic [ADDR_WIDTH-1:0]       rd_addr,
    input  logic                        rd_done,
    output logic                        rd_ready,
    output logic [DATAWIDTH*N_SIZE-1:0] rd_data,
    output logic                        rd_valid,
    output logic [2:0]                  err
);

    localparam int ROW_W = DATAWIDTH * N_SIZE;
    // One extra bit so the bound still fits when DEPTH == 2**ADDR_WIDTH.
    localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH + 1)'(DEPTH);

    logic [ROW_W-1:0] mem [2][DEPTH];

    // Bank control state
    logic       wr_sel, rd_sel, wr_sel_nxt, rd_sel_nxt;
    logic [1:0] full, full_nxt;

    // Accumulate write-back stage
    logic                  wb_pend;
    logic                  wb_bank;
    logic [ADDR_WIDTH-1:0] wb_addr;
    logic [N_SIZE-1:0]     wb_mask;
    logic [ROW_W-1:0]      wb_data, wb_old, wb_sum, acc_old;

    logic wr_in_range, rd_in_range;
    logic wr_go, ow_go, acc_go, rd_go, wdone_go, rdone_go;
    logic err_wr, err_rd, err_addr;

    assign wr_in_range = {1'b0, wr_addr} < DEPTH_LIM;
    assign rd_in_range = {1'b0, rd_addr} < DEPTH_LIM;
    assign wr_go       = wr_en && wr_ready && wr_in_range;
    assign ow_go       = wr_go && !wr_acc;
    assign acc_go      = wr_go && wr_acc;
    assign rd_go       = rd_en && rd_ready && rd_in_range;
    assign wdone_go    = wr_done && wr_ready;
    assign rdone_go    = rd_done && rd_ready;

    assign err_wr   = (wr_en || wr_done) && !wr_ready;
    assign err_rd   = (rd_en || rd_done) && !rd_ready;
    assign err_addr = (wr_en && !wr_in_range) || (rd_en && !rd_in_range);

    // ---------------- bank control: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_sel <= 1'b0;
            rd_sel <= 1'b0;
            full   <= '0;
        end else begin
            wr_sel <= wr_sel_nxt;
            rd_sel <= rd_sel_nxt;
            full   <= full_nxt;
        end
    end

    // ---------------- bank control: next state ----------------
    // A valid wr_done and a valid rd_done can never target the same bank
    // (one needs it empty, the other full), so both updates compose.
    always_comb begin
        full_nxt   = full;
        wr_sel_nxt = wr_sel;
        rd_sel_nxt = rd_sel;
        if (wdone_go) begin
            full_nxt[wr_sel] = 1'b1;
            wr_sel_nxt       = ~wr_sel;
        end
        if (rdone_go) begin
            full_nxt[rd_sel] = 1'b0;
            rd_sel_nxt       = ~rd_sel;
        end
    end

    // ---------------- bank control: outputs ----------------
    // A write-back still in flight to the read bank hides it for one cycle.
    always_comb begin
        wr_ready = !full[wr_sel];
        rd_ready = full[rd_sel] && !(wb_pend && (wb_bank == rd_sel));
    end

    // ---------------- accumulate datapath ----------------
    always_comb begin
        wb_sum = wb_old;
        for (int unsigned i = 0; i < N_SIZE; i++) begin
            if (wb_mask[i])
                wb_sum[i*DATAWIDTH +: DATAWIDTH] = wb_old[i*DATAWIDTH +: DATAWIDTH]
                                                 + wb_data[i*DATAWIDTH +: DATAWIDTH];
        end
    end

    // Forward the in-flight sum when stage 0 hits the row being written back.
    always_comb begin
        if (wb_pend && (wb_bank == wr_sel) && (wb_addr == wr_addr))
            acc_old = wb_sum;
        else
            acc_old = mem[wr_sel][wr_addr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            wb_pend <= 1'b0;
        else
            wb_pend <= acc_go;
    end

    always_ff @(posedge clk) begin
        if (acc_go) begin
            wb_bank <= wr_sel;
            wb_addr <= wr_addr;
            wb_mask <= wr_mask;
            wb_data <= wr_data;
            wb_old  <= acc_old;
        end
    end

    // ---------------- storage ----------------
    // Write-back retires to its captured bank; a same-edge overwrite of the
    // same row is the younger operation and is applied last.
    always_ff @(posedge clk) begin
        if (wb_pend) begin
            for (int unsigned i = 0; i < N_SIZE; i++) begin
                if (wb_mask[i])
                    mem[wb_bank][wb_addr][i*DATAWIDTH +: DATAWIDTH] <=
                        wb_sum[i*DATAWIDTH +: DATAWIDTH];
            end
        end
        if (ow_go) begin
            for (int unsigned i = 0; i < N_SIZE; i++) begin
                if (wr_mask[i])
                    mem[wr_sel][wr_addr][i*DATAWIDTH +: DATAWIDTH] <=
                        wr_data[i*DATAWIDTH +: DATAWIDTH];
            end
        end
    end

    // ---------------- read port and error flags ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
            err      <= '0;
        end else begin
            rd_valid <= rd_go;
            if (rd_go)
                rd_data <= mem[rd_sel][rd_addr];
            err <= err | {err_addr, err_rd, err_wr};
        end
    end

endmodule

// File: doc/systolic_pingpong_buffer.md
# systolic_pingpong_buffer

Double-banked (ping-pong) output buffer for the systolic array. It stores one `N_SIZE`-lane result row per address. Its write side supports per-lane masking and an accumulate mode, which sums partial results across K-tiles in place. The array fills one bank while the downstream consumer (softmax/layernorm/DMA) drains the other; bank ownership is exchanged through a done/ready handshake.

## Interface
- `DATAWIDTH`, 32: bits per lane, two's-complement.
- `N_SIZE`, 32: lanes per row.
- `DEPTH`, 543: rows per bank (512 + 31 skew rows).
- `ADDR_WIDTH`, 10: address width; must satisfy 2^ADDR_WIDTH ≥ DEPTH.
- `clk` in 1: clock; all logic on rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `wr_en` in 1: write row `wr_addr` of the current write bank.
- `wr_addr` in ADDR_WIDTH: write row address.
- `wr_mask` in N_SIZE: per-lane write enable; bit i gates lane i.
- `wr_acc` in 1: 1 = add `wr_data` to the stored lane; 0 = overwrite.
- `wr_data` in DATAWIDTH*N_SIZE: lane i at bits [i*DATAWIDTH +: DATAWIDTH].
- `wr_done` in 1: producer finished the current write bank; hand it to the reader.
- `wr_ready` out 1: current write bank is free.
- `rd_en` in 1: read row `rd_addr` of the current read bank.
- `rd_addr` in ADDR_WIDTH: read row address.
- `rd_done` in 1: consumer finished the current read bank; release it.
- `rd_ready` out 1: current read bank holds a complete tile.
- `rd_data` out DATAWIDTH*N_SIZE: registered read data.
- `rd_valid` out 1: `rd_data` is valid this cycle.
- `err` out 3: sticky error flags; [0] write rejected, [1] read rejected, [2] address ≥ DEPTH.

## Operation
- **Storage:** two banks, each `DEPTH` × `N_SIZE*DATAWIDTH`. Memory contents are not reset.
- **State registers:** `wr_sel`, `rd_sel` (bank pointers) and `full[1:0]`.
  - `wr_ready = !full[wr_sel]`.
  - `rd_ready = full[rd_sel] && !(wb_pend && wb_bank == rd_sel)`.
- **Bank state per bank:** EMPTY → (`wr_done` while it is the write bank) → FULL → (`rd_done` while it is the read bank) → EMPTY.
  - `wr_done` sets `full[wr_sel]` and toggles `wr_sel`.
  - `rd_done` clears `full[rd_sel]` and toggles `rd_sel`.
  - `wr_done` when `wr_ready` = 0 is ignored and sets `err[0]`. `rd_done` when `rd_ready` = 0 is ignored and sets `err[1]`.
- **Write, overwrite mode:** `wr_en && wr_ready && wr_addr < DEPTH && !wr_acc` writes the masked lanes. Unmasked lanes keep their old value.
- **Write, accumulate mode:** a two-stage read-modify-write.
  - Stage 0 reads the old row and captures addr, bank, mask and data into the write-back register, setting `wb_pend`.
  - Stage 1 writes `old + data` per masked lane, modulo 2^DATAWIDTH (wrap, no saturation).
  - If the stage-0 address and bank match the pending write-back, the old row is forwarded from the stage-1 sum, not read from memory. Back-to-back accumulates to one address must sum correctly.
  - A write-back always retires to its captured bank, even if `wr_done` swapped banks meanwhile.
- **Rejected writes:** `wr_en` while `wr_ready` = 0 is dropped and sets `err[0]`.
- **Reads:** `rd_en && rd_ready && rd_addr < DEPTH` loads `rd_data` from bank `rd_sel`. Otherwise `rd_data` holds its previous value.
  - `rd_en` while `rd_ready` = 0 sets `err[1]`.
- **Address range:** any enabled access with addr ≥ DEPTH is dropped and sets `err[2]`.
- **Simultaneous events:**
  - `wr_en` + `wr_done` in one cycle: the write lands in the old bank, then the swap occurs.
  - `rd_en` + `rd_done` in one cycle: the read is served from the old bank, then the release occurs.
  - `wr_done` and `rd_done` on different banks in one cycle both take effect.
- **Reset mid-operation:** pointers, flags, the write-back stage and the outputs clear immediately. A pending accumulate is lost, and memory contents are undefined for the bank being written.

## Timing
- Reset values:
  - `rd_data` = 0, `rd_valid` = 0, `err` = 0, `wr_sel` = `rd_sel` = 0, `full` = 0, `wb_pend` = 0.
  - Hence `wr_ready` = 1 and `rd_ready` = 0.
- Read latency is 1 cycle: an accepted `rd_en` at edge N gives `rd_valid` = 1 with data after edge N, for one cycle.
- Overwrite data is visible to a read issued the cycle after the write edge.
- Accumulate results commit one cycle after the `wr_en` edge. The pending write-back holds `rd_ready` low for that bank for one cycle.
- `wr_ready` and `rd_ready` update the cycle after the `wr_done`/`rd_done` edge.
- Peak throughput: one write and one read per cycle, including back-to-back accumulates.

## Test plan
- **Reset then fill:** overwrite bank 0 rows 0..542 with lane i = addr*32+i, then `wr_done`. Then `rd_ready` = 1 and `wr_ready` = 1 (bank 1). Reading row 5 returns lane 3 = 163 with a 1-cycle `rd_valid`.
- **Accumulate chain:** write 0x7FFFFFFF to row 0, then accumulate +1 for three consecutive cycles on row 0. Row 0 = 0x80000002 (wrapped); forwarding is checked.
- **Mask:** write all 0xAA to row 7, then overwrite with 0x55 and `wr_mask` = 0x0000_0001. Lane 0 = 0x55, lanes 1..31 = 0xAA.
- **Ping-pong:** fill both banks, then `wr_en`. The write is dropped, `err[0]` = 1 and `wr_ready` = 0. After `rd_done`, `wr_ready` = 1 with `wr_sel` = 0 and `rd_ready` = 1 for bank 1.
- **Simultaneous:** `wr_done` and `rd_done` in the same cycle on opposite banks both swap. `rd_en` with `rd_done` returns old-bank data.
- **Errors and reset:** access at addr 543 sets `err[2]` with memory unchanged. Asserting `rst_n` low mid-accumulate clears all flags, `rd_valid`, `err` and `rd_data` asynchronously.
